// File: rtl/am2923_scan_pkg.sv
// Shared definitions for the am2923 condition scanner: FSM state encodings
// and the settle-counter width.
package am2923_scan_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEL    = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/am2923_prienc8.sv
// Lowest-set-bit encoder: idx is the index of the lowest 1 in vec,
// vld flags that any bit is set (idx is 0 when vld is 0).
module am2923_prienc8 (
  input  logic [7:0] vec,
  output logic [2:0] idx,
  output logic       vld
);

  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 3'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/am2923_scan.sv
// am2923 8-to-1 mux condition scanner: walks enabled channels, captures y into
// a parallel word. Optional change-detect outputs under AM2923_SCAN_CHG_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | mux strobed off, waiting for start
// ST_SEL    | select driven, strobe low, settle counter running down
// ST_SAMPLE | y_in captured into shadow[idx], pick next enabled channel
// ST_DONE   | done pulse; data/hit/hit_idx valid; cont relaunches a scan
module am2923_scan
  import am2923_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 0
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       start,
  input  logic       cont,
  input  logic [7:0] mask,
  input  logic       y_in,
  output logic       c,
  output logic       b,
  output logic       a,
  output logic       s_,
  output logic       busy,
  output logic       done,
  output logic [7:0] data,
  output logic       hit,
  output logic [2:0] hit_idx
`ifdef AM2923_SCAN_CHG_EN
  ,
  output logic       chg,
  output logic [7:0] chg_bits
`endif
);

  state_t           state, state_nx;
  logic [2:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       mask_q;
  logic [7:0]       shadow, shadow_nx;
  logic             launch;

  logic [7:0]       nxt_vec;
  logic [2:0]       nxt_idx;
  logic             nxt_vld;
  logic [2:0]       hit_i;
  logic             hit_vld;

  // One encoder serves both the first channel of a new scan (from the live
  // mask) and the next channel above idx (from the latched mask).
  assign nxt_vec = (state == ST_IDLE || state == ST_DONE) ? mask
                                                          : (mask_q & (8'hFE << idx));

  am2923_prienc8 u_pe_next (
    .vec (nxt_vec),
    .idx (nxt_idx),
    .vld (nxt_vld)
  );

  am2923_prienc8 u_pe_hit (
    .vec (shadow_nx),
    .idx (hit_i),
    .vld (hit_vld)
  );

  always_comb begin
    state_nx  = state;
    launch    = 1'b0;
    shadow_nx = shadow;
    case (state)
      ST_IDLE:   launch = start;
      ST_SEL:    if (cnt == '0) state_nx = ST_SAMPLE;
      ST_SAMPLE: begin
        shadow_nx[idx] = y_in;
        state_nx       = nxt_vld ? ST_SEL : ST_DONE;
      end
      ST_DONE: begin
        launch   = cont;
        state_nx = ST_IDLE;
      end
      default:   state_nx = ST_IDLE;
    endcase
    if (launch) begin
      shadow_nx = '0;
      state_nx  = nxt_vld ? ST_SEL : ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state  <= ST_IDLE;
      idx    <= '0;
      cnt    <= '0;
      mask_q <= '0;
      shadow <= '0;
    end else begin
      state  <= state_nx;
      shadow <= shadow_nx;
      if (launch) begin
        mask_q <= mask;
        idx    <= nxt_idx;
        cnt    <= CNT_W'(SETTLE);
      end else if (state == ST_SEL && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end else if (state == ST_SAMPLE && nxt_vld) begin
        idx <= nxt_idx;
        cnt <= CNT_W'(SETTLE);
      end
    end
  end

  // Results are registered on the edge that enters DONE, including the
  // channel sampled on that same edge.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      data    <= '0;
      hit     <= 1'b0;
      hit_idx <= '0;
`ifdef AM2923_SCAN_CHG_EN
      chg      <= 1'b0;
      chg_bits <= '0;
`endif
    end else begin
`ifdef AM2923_SCAN_CHG_EN
      chg <= 1'b0;
`endif
      if (state_nx == ST_DONE) begin
        data    <= shadow_nx;
        hit     <= hit_vld;
        hit_idx <= hit_i;
`ifdef AM2923_SCAN_CHG_EN
        chg      <= (shadow_nx != data);
        chg_bits <= shadow_nx ^ data;
`endif
      end
    end
  end

  logic drive_sel;
  assign drive_sel   = (state == ST_SEL) || (state == ST_SAMPLE);
  assign {c, b, a}   = drive_sel ? idx : 3'd0;
  assign s_          = ~drive_sel;
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);

endmodule
